// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature decoder.
package quad_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    // Forward order with A leading B: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] fwd_next(input logic [1:0] q);
        case (q)
            Q00:     return Q10;
            Q10:     return Q11;
            Q11:     return Q01;
            default: return Q00;
        endcase
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: two-flop synchroniser followed by a consecutive-cycle
// debounce filter.
module quad_debounce
    import quad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 4);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any return to the filtered level discards the partial count.
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front end: debounced A/B phases decoded into step/up/error pulses.
//   state | meaning
//   INIT  | settle after reset; prev follows q, outputs held at 0
//   TRACK | compare q against prev each cycle and emit step or error
module quad_decoder
    import quad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    output logic step,
    output logic up,
    output logic error
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 4);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(DEBOUNCE_CYCLES + 2);

    state_t        state;
    logic [CW-1:0] settle;
    logic          fa;
    logic          fb;
    logic [1:0]    q;
    logic [1:0]    prev;

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clock (clock),
        .reset (reset),
        .raw   (a_in),
        .filt  (fa)
    );

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clock (clock),
        .reset (reset),
        .raw   (b_in),
        .filt  (fb)
    );

    assign q = {fa, fb};

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= INIT;
            settle <= '0;
            prev   <= Q00;
            step   <= 1'b0;
            up     <= 1'b0;
            error  <= 1'b0;
        end else begin
            step  <= 1'b0;
            error <= 1'b0;
            prev  <= q;
            case (state)
                INIT: begin
                    up <= 1'b0;
                    if (settle == SETTLE_LAST) begin
                        state <= TRACK;
                    end else begin
                        settle <= settle + 1'b1;
                    end
                end
                TRACK: begin
                    if (q != prev) begin
                        if (q == fwd_next(prev)) begin
                            step <= 1'b1;
                            up   <= 1'b1;
                        end else if (fwd_next(q) == prev) begin
                            step <= 1'b1;
                            up   <= 1'b0;
                        end else begin
                            // Both phases moved at once: direction is unknown, keep up.
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
